trig_holdoff_sched: RTL and testbench

- Multi-source trigger scheduler for the acquisition/trigger path.
- Rising-edge-detects N digital trigger sources and arbitrates simultaneous edges round-robin.
- Enforces a programmable holdoff after every accepted trigger and sequences arm / one-shot / continuous operation.
- Output is a single-cycle trigger pulse plus source index, consumed by scope/IQ capture logic.

---
 rtl/trig_sched_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/trig_holdoff_sched.sv | 139 +++++++++++++
 tb/tb_trig_holdoff_sched.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_sched_pkg.sv
// Shared types and widths for the trigger holdoff scheduler.
package trig_sched_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      HOLDOFF = 2'd2
   } state_t;

   localparam int TRIG_CNT_W = 32;
   localparam int MISS_CNT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i,
// wrapping modulo N_SRC.
module rr_arbiter #(
   parameter int N_SRC = 4,
   localparam int SRC_W = $clog2(N_SRC)
) (
   input  logic [N_SRC-1:0] req_i,
   input  logic [SRC_W-1:0] ptr_i,
   output logic             grant_valid_o,
   output logic [SRC_W-1:0] grant_idx_o
);

   logic [SRC_W:0] w_idx;

   // Walk offsets high to low so the lowest offset from ptr wins.
   always_comb begin
      grant_valid_o = 1'b0;
      grant_idx_o   = '0;
      w_idx         = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         w_idx = {1'b0, ptr_i} + (SRC_W+1)'(i);
         if (w_idx >= (SRC_W+1)'(N_SRC))
            w_idx = w_idx - (SRC_W+1)'(N_SRC);
         if (req_i[w_idx]) begin
            grant_valid_o = 1'b1;
            grant_idx_o   = w_idx[SRC_W-1:0];
         end
      end
   end

endmodule

// File: rtl/trig_holdoff_sched.sv
// Multi-source trigger scheduler: edge detect, RR arbitration, holdoff.
// Define TRIG_HOLDOFF_SCHED_COUNT_EN to add trigger/miss counters.
module trig_holdoff_sched
   import trig_sched_pkg::*;
#(
   parameter int N_SRC     = 4,
   parameter int HOLDOFF_W = 16,
   localparam int SRC_W    = $clog2(N_SRC)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [N_SRC-1:0]     src_i,
   input  logic [N_SRC-1:0]     src_en_i,
   input  logic                 arm_i,
   input  logic                 disarm_i,
   input  logic                 continuous_i,
   input  logic [HOLDOFF_W-1:0] holdoff_i,
   output logic                 trig_o,
   output logic [SRC_W-1:0]     trig_src_o,
   output logic                 armed_o,
   output logic                 busy_o,
   output logic                 missed_o
`ifdef TRIG_HOLDOFF_SCHED_COUNT_EN
   ,
   output logic [TRIG_CNT_W-1:0] trig_count_o,
   output logic [MISS_CNT_W-1:0] miss_count_o
`endif
);

   state_t               r_state;
   logic [N_SRC-1:0]     r_src_d;
   logic [SRC_W-1:0]     r_ptr;
   logic [HOLDOFF_W-1:0] r_cnt;
   logic                 r_trig;
   logic [SRC_W-1:0]     r_trig_src;
   logic                 r_missed;

   logic [N_SRC-1:0]     w_rise;
   logic [N_SRC-1:0]     w_lose;
   logic                 w_gnt_vld;
   logic [SRC_W-1:0]     w_gnt;
   logic [SRC_W:0]       w_p1;
   logic [SRC_W-1:0]     w_ptr_nxt;
   logic                 w_accept;
   logic                 w_miss;
   logic                 w_arm_go;

   assign w_rise = src_i & ~r_src_d & src_en_i;
   assign w_lose = w_rise & ~(N_SRC'(1) << w_gnt);

   rr_arbiter #(.N_SRC(N_SRC)) u_arb (
      .req_i         (w_rise),
      .ptr_i         (r_ptr),
      .grant_valid_o (w_gnt_vld),
      .grant_idx_o   (w_gnt)
   );

   assign w_p1      = {1'b0, w_gnt} + (SRC_W+1)'(1);
   assign w_ptr_nxt = (w_p1 == (SRC_W+1)'(N_SRC)) ? '0 : w_p1[SRC_W-1:0];

   assign w_accept = !disarm_i && r_state == ARMED && w_gnt_vld;
   assign w_miss   = !disarm_i &&
                     ((r_state == ARMED && w_gnt_vld && |w_lose) ||
                      (r_state == HOLDOFF && |w_rise));
   assign w_arm_go = !disarm_i && r_state == IDLE && arm_i;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_src_d    <= '0;
         r_ptr      <= '0;
         r_cnt      <= '0;
         r_trig     <= 1'b0;
         r_trig_src <= '0;
         r_missed   <= 1'b0;
      end else begin
         r_src_d  <= src_i;
         r_trig   <= w_accept;
         r_missed <= w_miss;
         if (disarm_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               IDLE: if (arm_i) r_state <= ARMED;
               ARMED: if (w_gnt_vld) begin
                  r_trig_src <= w_gnt;
                  r_ptr      <= w_ptr_nxt;
                  r_cnt      <= holdoff_i;
                  if (holdoff_i == '0)
                     r_state <= continuous_i ? ARMED : IDLE;
                  else
                     r_state <= HOLDOFF;
               end
               HOLDOFF: begin
                  if (r_cnt == HOLDOFF_W'(1))
                     r_state <= continuous_i ? ARMED : IDLE;
                  else
                     r_cnt <= r_cnt - HOLDOFF_W'(1);
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign trig_o     = r_trig;
   assign trig_src_o = r_trig_src;
   assign armed_o    = (r_state == ARMED);
   assign busy_o     = (r_state == HOLDOFF);
   assign missed_o   = r_missed;

`ifdef TRIG_HOLDOFF_SCHED_COUNT_EN
   logic [TRIG_CNT_W-1:0] r_trig_cnt;
   logic [MISS_CNT_W-1:0] r_miss_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_trig_cnt <= '0;
         r_miss_cnt <= '0;
      end else if (w_arm_go) begin
         r_trig_cnt <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (w_accept && r_trig_cnt != '1)
            r_trig_cnt <= r_trig_cnt + TRIG_CNT_W'(1);
         if (w_miss && r_miss_cnt != '1)
            r_miss_cnt <= r_miss_cnt + MISS_CNT_W'(1);
      end
   end

   assign trig_count_o = r_trig_cnt;
   assign miss_count_o = r_miss_cnt;
`else
   logic w_unused;
   assign w_unused = w_arm_go;
`endif

endmodule

// File: tb/tb_trig_holdoff_sched.sv
// Self-checking bench for trig_holdoff_sched: directed scenarios with
// literal expectations plus a randomized run against an edge-count model.
module tb_trig_holdoff_sched;

   localparam int N = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [N-1:0]  src_i = '0;
   logic [N-1:0]  src_en_i = '1;
   logic          arm_i = 1'b0;
   logic          disarm_i = 1'b0;
   logic          continuous_i = 1'b0;
   logic [15:0]   holdoff_i = '0;
   logic          trig_o;
   logic [1:0]    trig_src_o;
   logic          armed_o;
   logic          busy_o;
   logic          missed_o;
`ifdef TRIG_HOLDOFF_SCHED_COUNT_EN
   logic [31:0]   trig_count_o;
   logic [15:0]   miss_count_o;
`endif

   trig_holdoff_sched #(.N_SRC(N), .HOLDOFF_W(16)) dut (
      .clock        (clock),
      .reset        (reset),
      .src_i        (src_i),
      .src_en_i     (src_en_i),
      .arm_i        (arm_i),
      .disarm_i     (disarm_i),
      .continuous_i (continuous_i),
      .holdoff_i    (holdoff_i),
      .trig_o       (trig_o),
      .trig_src_o   (trig_src_o),
      .armed_o      (armed_o),
      .busy_o       (busy_o),
      .missed_o     (missed_o)
`ifdef TRIG_HOLDOFF_SCHED_COUNT_EN
      ,
      .trig_count_o (trig_count_o),
      .miss_count_o (miss_count_o)
`endif
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: mode 0=idle 1=armed 2=in holdoff; holdoff ends at edge hold_end.
   int       edge_n = 0;
   int       m_mode = 0;
   int       m_hold_end = 0;
   int       m_ptr = 0;
   int       m_prev = 0;
   int       e_trig = 0;
   int       e_src = 0;
   int       e_missed = 0;
   longint   m_tc = 0;
   int       m_mc = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_ptr = 0; m_prev = 0;
      e_trig = 0; e_src = 0; e_missed = 0;
      m_tc = 0; m_mc = 0; m_hold_end = 0;
   endtask

   task automatic model_edge();
      int rise, g, idx, ones;
      edge_n++;
      rise = int'(src_i) & ~m_prev & int'(src_en_i) & 32'hF;
      m_prev = int'(src_i);
      e_trig = 0;
      e_missed = 0;
      if (disarm_i) begin
         m_mode = 0;
      end else if (m_mode == 0) begin
         if (arm_i) begin
            m_mode = 1; m_tc = 0; m_mc = 0;
         end
      end else if (m_mode == 1) begin
         if (rise != 0) begin
            g = -1;
            for (int off = 0; off < N; off++) begin
               idx = (m_ptr + off) % N;
               if (g < 0 && rise[idx]) g = idx;
            end
            ones = $countones(rise);
            e_trig = 1; e_src = g;
            m_ptr = (g + 1) % N;
            e_missed = (ones > 1) ? 1 : 0;
            m_tc++;
            if (e_missed != 0) m_mc++;
            if (holdoff_i == 0) m_mode = continuous_i ? 1 : 0;
            else begin
               m_mode = 2;
               m_hold_end = edge_n + int'(holdoff_i);
            end
         end
      end else begin
         if (rise != 0) begin
            e_missed = 1; m_mc++;
         end
         if (edge_n == m_hold_end) m_mode = continuous_i ? 1 : 0;
      end
   endtask

   task automatic compare_all();
      chk("trig_o", trig_o, e_trig);
      if (e_trig != 0) chk("trig_src_o", trig_src_o, e_src);
      chk("armed_o", armed_o, m_mode == 1);
      chk("busy_o", busy_o, m_mode == 2);
      chk("missed_o", missed_o, e_missed);
`ifdef TRIG_HOLDOFF_SCHED_COUNT_EN
      chk("trig_count_o", trig_count_o, m_tc);
      chk("miss_count_o", miss_count_o, m_mc);
`endif
   endtask

   task automatic step(input logic [N-1:0] s, input logic [N-1:0] en,
                       input logic a, input logic d, input logic c,
                       input logic [15:0] h);
      src_i = s; src_en_i = en; arm_i = a; disarm_i = d;
      continuous_i = c; holdoff_i = h;
      @(posedge clock);
      model_edge();
      @(negedge clock);
      compare_all();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      src_i = '0; arm_i = 0; disarm_i = 0;
      @(posedge clock);
      @(negedge clock);
      model_reset();
      reset = 1'b0;
   endtask

   initial begin : main
      logic [N-1:0] cur;
      logic [N-1:0] en;
      do_reset();
      chk("rst_trig", trig_o, 0);
      chk("rst_src", trig_src_o, 0);
      chk("rst_armed", armed_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_missed", missed_o, 0);

      // One-shot, holdoff 3, pulse on source 2.
      step(4'h0, 4'hF, 1, 0, 0, 3);
      chk("t1_armed", armed_o, 1);
      step(4'h4, 4'hF, 0, 0, 0, 3);
      chk("t1_trig", trig_o, 1);
      chk("t1_src", trig_src_o, 2);
      chk("t1_busy0", busy_o, 1);
      step(4'h0, 4'hF, 0, 0, 0, 3);
      chk("t1_trig_off", trig_o, 0);
      chk("t1_busy1", busy_o, 1);
      step(4'h0, 4'hF, 0, 0, 0, 3);
      chk("t1_busy2", busy_o, 1);
      step(4'h0, 4'hF, 0, 0, 0, 3);
      chk("t1_busy3", busy_o, 0);
      chk("t1_armed_end", armed_o, 0);

      // Continuous, holdoff 4, source 0 rising every second edge.
      do_reset();
      step(4'h0, 4'hF, 1, 0, 1, 4);
      for (int i = 0; i < 8; i++) begin
         step((i % 2 == 0) ? 4'h1 : 4'h0, 4'hF, 0, 0, 1, 4);
         chk("t2_trig", trig_o, (i == 0 || i == 6) ? 1 : 0);
         chk("t2_missed", missed_o, (i == 2 || i == 4) ? 1 : 0);
      end

      // Simultaneous rises on 1 and 3 from pointer 0, then from pointer 2.
      do_reset();
      step(4'h0, 4'hF, 1, 0, 1, 1);
      step(4'hA, 4'hF, 0, 0, 1, 1);
      chk("t3_src_a", trig_src_o, 1);
      chk("t3_miss_a", missed_o, 1);
      step(4'h0, 4'hF, 0, 0, 1, 1);
      chk("t3_rearmed", armed_o, 1);
      step(4'hA, 4'hF, 0, 0, 1, 1);
      chk("t3_trig_b", trig_o, 1);
      chk("t3_src_b", trig_src_o, 3);
      chk("t3_miss_b", missed_o, 1);

      // Level held high across arm must not trigger.
      do_reset();
      step(4'h1, 4'hF, 0, 0, 1, 0);
      step(4'h1, 4'hF, 1, 0, 1, 0);
      step(4'h1, 4'hF, 0, 0, 1, 0);
      chk("t4_no_trig", trig_o, 0);
      step(4'h0, 4'hF, 0, 0, 1, 0);
      step(4'h1, 4'hF, 0, 0, 1, 0);
      chk("t4_trig", trig_o, 1);
      chk("t4_src", trig_src_o, 0);

      // Disarm coincident with a rise; then async reset inside holdoff.
      step(4'h0, 4'hF, 0, 0, 1, 5);
      step(4'h1, 4'hF, 0, 1, 1, 5);
      chk("t5_no_trig", trig_o, 0);
      chk("t5_idle", armed_o, 0);
      step(4'h0, 4'hF, 1, 0, 1, 5);
      step(4'h2, 4'hF, 0, 0, 1, 5);
      chk("t5_trig", trig_o, 1);
      chk("t5_busy", busy_o, 1);
      #2 reset = 1'b1;
      #1;
      chk("t5_rst_trig", trig_o, 0);
      chk("t5_rst_busy", busy_o, 0);
      chk("t5_rst_src", trig_src_o, 0);
      @(negedge clock);
      model_reset();
      reset = 1'b0;

`ifdef TRIG_HOLDOFF_SCHED_COUNT_EN
      step(4'h0, 4'hF, 1, 0, 1, 0);
      for (int i = 0; i < 10; i++)
         step((i % 2 == 0) ? 4'h8 : 4'h0, 4'hF, 0, 0, 1, 0);
      chk("t6_count5", trig_count_o, 5);
      step(4'h0, 4'hF, 0, 1, 1, 0);
      step(4'h0, 4'hF, 1, 0, 1, 0);
      chk("t6_cleared", trig_count_o, 0);
`endif

      // Randomized run against the model.
      do_reset();
      cur = '0;
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < N; b++)
            if ($urandom_range(2) == 0) cur[b] = ~cur[b];
         en = ($urandom_range(5) == 0) ? N'($urandom) : '1;
         step(cur, en,
              $urandom_range(7) == 0,
              $urandom_range(59) == 0,
              $urandom_range(3) != 0,
              16'($urandom_range(6)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
